// File: rtl/instruction_ram_if.sv
// Load and fetch signal bundle for instruction_ram.
// The master drives the load and fetch requests; the slave is the RAM block.
interface instruction_ram_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  reload;
  logic [31:0]           fetch_addr;
  logic                  fetch_stall;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  instr_valid;
  logic                  fetch_fault;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  load_overflow;
  logic                  running;

  modport master (
    output load_valid, load_data, load_done, reload, fetch_addr, fetch_stall,
    input  load_ready, instruction, instr_valid, fetch_fault, word_count,
           load_overflow, running
  );

  modport slave (
    input  load_valid, load_data, load_done, reload, fetch_addr, fetch_stall,
    output load_ready, instruction, instr_valid, fetch_fault, word_count,
           load_overflow, running
  );
endinterface

// File: rtl/instruction_ram.sv
// Instruction RAM with a BOOT load phase and a RUN fetch phase.
// Words are streamed in sequentially during BOOT; in RUN a registered fetch
// returns the word at the PC byte address, or NOP_WORD with a fault flag.
// Memory contents survive reset and reload; only the bookkeeping is cleared.
module instruction_ram #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic               clk,
  input logic               reset,
  instruction_ram_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  load_overflow_q, load_overflow_d;
  logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fetch_fault_q, fetch_fault_d;

  logic                  running;
  logic                  load_accept;
  logic                  mem_full;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  fetch_hi_set;
  logic                  fetch_bad;

  assign mem_full     = (word_count_q == FULL_COUNT);
  assign fetch_idx    = bus.fetch_addr[ADDR_WIDTH+1:2];
  assign fetch_hi_set = ((bus.fetch_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign fetch_bad    = (bus.fetch_addr[1:0] != 2'b00) || fetch_hi_set ||
                        ({1'b0, fetch_idx} >= word_count_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next state: reload takes priority over load_done
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: if (bus.load_done && !bus.reload) state_d = RUN;
      RUN:  if (bus.reload)                   state_d = BOOT;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs; load_ready is gated by reset so it drops immediately
  always_comb begin
    running     = (state_q == RUN);
    load_accept = !reset && (state_q == BOOT) && bus.load_valid && !mem_full;
  end

  // Load bookkeeping and registered fetch result
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    word_count_d    = word_count_q;
    load_overflow_d = load_overflow_q;
    instruction_d   = instruction_q;
    instr_valid_d   = instr_valid_q;
    fetch_fault_d   = fetch_fault_q;
    mem_we          = 1'b0;
    if (state_q == BOOT) begin
      mem_we        = load_accept;
      instruction_d = NOP_WORD;
      instr_valid_d = 1'b0;
      fetch_fault_d = 1'b0;
      if (load_accept) begin
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
        word_count_d = word_count_q + (ADDR_WIDTH + 1)'(1);
      end
      if (bus.load_valid && mem_full) load_overflow_d = 1'b1;
      if (bus.reload) begin
        wr_ptr_d        = '0;
        word_count_d    = '0;
        load_overflow_d = 1'b0;
      end
    end else if (bus.reload) begin
      // reload overrides a stall: the fetch outputs clear on this edge
      wr_ptr_d        = '0;
      word_count_d    = '0;
      load_overflow_d = 1'b0;
      instruction_d   = NOP_WORD;
      instr_valid_d   = 1'b0;
      fetch_fault_d   = 1'b0;
    end else if (!bus.fetch_stall) begin
      if (fetch_bad) begin
        instruction_d = NOP_WORD;
        instr_valid_d = 1'b0;
        fetch_fault_d = 1'b1;
      end else begin
        instruction_d = mem_q[fetch_idx];
        instr_valid_d = 1'b1;
        fetch_fault_d = 1'b0;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      word_count_q    <= '0;
      load_overflow_q <= 1'b0;
      instruction_q   <= NOP_WORD;
      instr_valid_q   <= 1'b0;
      fetch_fault_q   <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      word_count_q    <= word_count_d;
      load_overflow_q <= load_overflow_d;
      instruction_q   <= instruction_d;
      instr_valid_q   <= instr_valid_d;
      fetch_fault_q   <= fetch_fault_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.load_data;
  end

  assign bus.load_ready    = load_accept;
  assign bus.running       = running;
  assign bus.instruction   = instruction_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.fetch_fault   = fetch_fault_q;
  assign bus.word_count    = word_count_q;
  assign bus.load_overflow = load_overflow_q;

endmodule

// File: tb/tb_instruction_ram.sv
// Bench for instruction_ram: directed scenarios plus randomized traffic,
// checked against a behavioural model of the load/fetch rules.
module tb_instruction_ram;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic reset;

  instruction_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if8 ();
  instruction_ram_if #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) if2 ();

  instruction_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NOP_WORD(NOP)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  instruction_ram #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .NOP_WORD(NOP)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model of the 256-word instance
  logic [31:0] m_mem [DEPTH];
  int unsigned m_cnt;
  bit          m_run, m_ovf, m_iv, m_ff;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_ovf = 0; m_iv = 0; m_ff = 0; m_instr = NOP;
  endtask

  task automatic model_update();
    logic [31:0] fa;
    fa = if8.fetch_addr;
    if (!m_run) begin
      if (if8.load_valid) begin
        if (m_cnt < DEPTH) begin
          m_mem[m_cnt] = if8.load_data;
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      m_instr = NOP; m_iv = 0; m_ff = 0;
      if (if8.reload) begin
        m_cnt = 0; m_ovf = 0;
      end else if (if8.load_done) begin
        m_run = 1;
      end
    end else if (if8.reload) begin
      m_run = 0; m_cnt = 0; m_ovf = 0;
      m_instr = NOP; m_iv = 0; m_ff = 0;
    end else if (!if8.fetch_stall) begin
      if ((fa % 4) != 0 || fa >= 4 * DEPTH || (fa / 4) >= m_cnt) begin
        m_instr = NOP; m_iv = 0; m_ff = 1;
      end else begin
        m_instr = m_mem[fa / 4]; m_iv = 1; m_ff = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("instruction", if8.instruction, m_instr);
    chk("instr_valid", if8.instr_valid, m_iv);
    chk("fetch_fault", if8.fetch_fault, m_ff);
    chk("word_count", if8.word_count, m_cnt);
    chk("load_overflow", if8.load_overflow, m_ovf);
    chk("running", if8.running, m_run);
  endtask

  // One clock: check load_ready before the edge, advance model, check after
  task automatic cyc();
    bit rdy;
    #1;
    rdy = !m_run && if8.load_valid && (m_cnt < DEPTH);
    chk("load_ready", if8.load_ready, rdy);
    @(posedge clk);
    model_update();
    #1;
    check_outs();
  endtask

  task automatic idle8();
    if8.load_valid = 0; if8.load_data = '0; if8.load_done = 0;
    if8.reload = 0; if8.fetch_addr = '0; if8.fetch_stall = 0;
  endtask

  task automatic load8(input logic [31:0] d);
    if8.load_valid = 1; if8.load_data = d;
    cyc();
    if8.load_valid = 0;
  endtask

  task automatic done8();
    if8.load_done = 1;
    cyc();
    if8.load_done = 0;
  endtask

  task automatic fetch8(input logic [31:0] a);
    if8.fetch_addr = a;
    cyc();
  endtask

  initial begin
    idle8();
    if2.load_valid = 0; if2.load_data = '0; if2.load_done = 0;
    if2.reload = 0; if2.fetch_addr = '0; if2.fetch_stall = 0;
    model_reset();

    // Reset values, with load_valid held high to show load_ready is masked
    reset = 1;
    if8.load_valid = 1;
    #1;
    check_outs();
    chk("reset_load_ready", if8.load_ready, 1'b0);
    #6 reset = 0;
    if8.load_valid = 0;

    // Sequential load then fetch
    load8(32'h241d0100);
    load8(32'h24040000);
    load8(32'h8c850000);
    done8();
    chk("run_after_done", if8.running, 1'b1);
    chk("count3", if8.word_count, 9'd3);
    fetch8(32'h0); chk("fetch0", if8.instruction, 32'h241d0100);
    fetch8(32'h4); chk("fetch4", if8.instruction, 32'h24040000);
    fetch8(32'h8); chk("fetch8", if8.instruction, 32'h8c850000);
    chk("fetch8_valid", if8.instr_valid, 1'b1);

    // Fault cases
    fetch8(32'h2);   chk("misalign_fault", if8.fetch_fault, 1'b1);
    fetch8(32'hC);   chk("range_fault", if8.fetch_fault, 1'b1);
                     chk("range_nop", if8.instruction, NOP);
    fetch8(32'h400); chk("high_fault", if8.fetch_fault, 1'b1);
                     chk("high_valid", if8.instr_valid, 1'b0);

    // Stall hold
    fetch8(32'h4);
    if8.fetch_stall = 1;
    if8.fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", if8.instruction, 32'h24040000);
    end
    if8.fetch_stall = 0;
    cyc();
    chk("stall_release", if8.instruction, 32'h8c850000);

    // Reload together with load_done
    if8.reload = 1; if8.load_done = 1;
    cyc();
    if8.reload = 0; if8.load_done = 0;
    chk("reload_boot", if8.running, 1'b0);
    chk("reload_count", if8.word_count, 9'd0);
    chk("reload_ivalid", if8.instr_valid, 1'b0);
    load8(32'hdeadbeef);
    done8();
    fetch8(32'h4); chk("reload_fault4", if8.fetch_fault, 1'b1);
    fetch8(32'h0); chk("reload_fetch0", if8.instruction, 32'hdeadbeef);

    // Overflow on the 4-word instance; dut8 stays stalled meanwhile
    if8.fetch_stall = 1;
    for (int i = 0; i < 5; i++) begin
      if2.load_valid = 1;
      if2.load_data = 32'hA0 + 32'(i);
      #1;
      chk("ovf_ready", if2.load_ready, (i < 4) ? 1'b1 : 1'b0);
      cyc();
    end
    if2.load_valid = 0;
    chk("ovf_flag", if2.load_overflow, 1'b1);
    chk("ovf_count", if2.word_count, 3'd4);
    if2.load_done = 1; cyc(); if2.load_done = 0;
    if2.fetch_addr = 32'h0;  cyc(); chk("ovf_nowrap0", if2.instruction, 32'hA0);
    if2.fetch_addr = 32'hC;  cyc(); chk("ovf_word3", if2.instruction, 32'hA3);
    if2.fetch_addr = 32'h10; cyc(); chk("ovf_hi_fault", if2.fetch_fault, 1'b1);
    if8.fetch_stall = 0;

    // Asynchronous reset in the middle of a load
    if8.reload = 1; cyc(); if8.reload = 0;
    load8(32'h11111111);
    load8(32'h22222222);
    if8.load_valid = 1; if8.load_data = 32'h33333333;
    #3 reset = 1;
    #1;
    model_reset();
    chk("ar_count", if8.word_count, 9'd0);
    chk("ar_ready", if8.load_ready, 1'b0);
    chk("ar_running", if8.running, 1'b0);
    chk("ar_instr", if8.instruction, NOP);
    chk("ar_ovf2", if2.load_overflow, 1'b0);
    check_outs();
    #2 reset = 0;
    if8.load_valid = 0;
    load8(32'h44444444);
    done8();
    fetch8(32'h4); chk("ar_fault4", if8.fetch_fault, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if8.load_valid  = 1'($urandom % 2);
      if8.load_data   = $urandom;
      if8.fetch_stall = ($urandom % 4) == 0;
      case ($urandom % 8)
        0:       if8.fetch_addr = $urandom;
        1:       if8.fetch_addr = 32'(($urandom % 256) * 4 + 1 + ($urandom % 3));
        default: if8.fetch_addr = 32'($urandom_range(0, m_cnt + 1) * 4);
      endcase
      if (!m_run) begin
        if8.reload    = 0;
        if8.load_done = ($urandom % 24) == 0;
      end else begin
        if8.reload    = ($urandom % 40) == 0;
        if8.load_done = 1'($urandom % 2);
      end
      cyc();
    end
    idle8();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
